// File: rtl/conv2d_pkg.sv
// conv2d_pkg
// Shared definitions for the conv2d output streaming path.
//   NUM_OUT_CHANNELS : output channels per pixel vector
//   PX_W_DEFAULT     : bits per quantised channel value
//   VEC_W_DEFAULT    : width of one packed pixel vector at the default sizes
//   px_vec_t         : packed pixel vector, channel 0 in the MSBs
package conv2d_pkg;

    localparam int NUM_OUT_CHANNELS = 16;
    localparam int PX_W_DEFAULT     = 8;
    localparam int VEC_W_DEFAULT    = NUM_OUT_CHANNELS * PX_W_DEFAULT;

    typedef logic [VEC_W_DEFAULT-1:0] px_vec_t;

endpackage

// File: rtl/conv2d_fifo_ram.sv
// conv2d_fifo_ram
// Simple dual-port storage for the output FIFO: one synchronous write port,
// one synchronous read port, no reset.
//   clk   : clock, rising edge
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address, sampled on the rising edge
//   rdata : registered read data (mem[raddr] as of that edge)
// A read and a write to the same address on one edge return the old contents;
// the FIFO top forwards the new word itself.
module conv2d_fifo_ram #(
    parameter int DW = 128,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [2**AW];

    // NOTE: the array has no reset so it maps onto block RAM; every word is
    // written before the FIFO ever presents it, so power-up contents are never seen.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/conv2d_stream_out_fifo.sv
// conv2d_stream_out_fifo
// First-word-fall-through FIFO that packs per-channel pixel values into one
// vector and streams them out with a registered valid/data output stage.
//   clk, rst     : clock (rising edge), asynchronous active-high reset
//   in_px_vec_q  : NUM_CH channel values of PX_W bits, channel i at index i
//   in_valid     : producer offers a vector
//   in_ready     : block accepts a vector this cycle (registered)
//   out_data     : packed vector, channel 0 in the MSBs
//   out_valid    : out_data holds a valid vector (registered)
//   out_ready    : consumer accepts out_data
//   flush        : synchronous discard of all contents, beats push/pop
//   level        : vectors held, including the one in the output register
//   almost_full  : level >= AFULL_TH
//   overflow     : sticky, set by in_valid while in_ready is low
//
// Every accepted vector is written to the RAM, including the one that falls
// straight through into the output register, so the RAM entry at rd_ptr is
// always the word on out_data and all DEPTH vectors fit in DEPTH entries.
// The RAM is continuously read one entry ahead of the output register, so a
// pop can load the next word on the same edge with no bubble.
module conv2d_stream_out_fifo
    import conv2d_pkg::*;
#(
    parameter int NUM_CH   = NUM_OUT_CHANNELS,
    parameter int PX_W     = PX_W_DEFAULT,
    parameter int DEPTH    = 32,
    parameter int AFULL_TH = DEPTH - 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_CH-1:0][PX_W-1:0] in_px_vec_q,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic [NUM_CH*PX_W-1:0]      out_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    input  logic                        flush,
    output logic [$clog2(DEPTH):0]      level,
    output logic                        almost_full,
    output logic                        overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int DW = NUM_CH * PX_W;

    // Registered state
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [LW-1:0] level_q;
    logic          in_ready_q;
    logic          out_valid_q;
    logic [DW-1:0] out_data_q;
    logic          overflow_q;
    logic          fwd_valid_q;   // word written on the last edge is the one read ahead
    logic [DW-1:0] fwd_data_q;

    // Next-state values
    logic [AW-1:0] wr_ptr_nxt, rd_ptr_nxt;
    logic [LW-1:0] level_nxt;
    logic          in_ready_nxt;
    logic          out_valid_nxt;
    logic [DW-1:0] out_data_nxt;
    logic          overflow_nxt;
    logic          fwd_valid_nxt;

    logic          push, pop;
    logic [DW-1:0] in_packed;
    logic [AW-1:0] raddr;
    logic [DW-1:0] ram_rdata;
    logic [DW-1:0] head_data;     // the word that follows the one on out_data

    // NOTE: every variable assigned in an always_comb gets a default first,
    // so no path through the block can leave it holding state (a latch).
    always_comb begin
        in_packed = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            in_packed[(NUM_CH-1-i)*PX_W +: PX_W] = in_px_vec_q[i];
        end
    end

    assign push = in_valid && in_ready_q;
    assign pop  = out_valid_q && out_ready;

    // Read one entry past where the output register will be after this edge.
    assign raddr     = rd_ptr_nxt + AW'(1);
    assign head_data = fwd_valid_q ? fwd_data_q : ram_rdata;

    conv2d_fifo_ram #(
        .DW (DW),
        .AW (AW)
    ) u_ram (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (in_packed),
        .raddr (raddr),
        .rdata (ram_rdata)
    );

    always_comb begin
        wr_ptr_nxt    = wr_ptr + AW'(push);
        rd_ptr_nxt    = rd_ptr + AW'(pop);
        level_nxt     = level_q;
        out_valid_nxt = out_valid_q;
        out_data_nxt  = out_data_q;
        overflow_nxt  = overflow_q || (in_valid && !in_ready_q);
        // The RAM returns old data when read and written at one address on
        // the same edge, so keep the new word aside for the next cycle.
        fwd_valid_nxt = push && (wr_ptr == raddr);

        case ({push, pop})
            2'b10:   level_nxt = level_q + LW'(1);
            2'b01:   level_nxt = level_q - LW'(1);
            default: level_nxt = level_q;
        endcase

        if (pop) begin
            if (level_q > LW'(1)) begin
                out_data_nxt = head_data;
            end else if (push) begin
                out_data_nxt = in_packed;
            end else begin
                out_valid_nxt = 1'b0;
            end
        end else if (!out_valid_q && push) begin
            out_valid_nxt = 1'b1;
            out_data_nxt  = in_packed;
        end

        if (flush) begin
            wr_ptr_nxt    = '0;
            rd_ptr_nxt    = '0;
            level_nxt     = '0;
            out_valid_nxt = 1'b0;
            overflow_nxt  = 1'b0;
            fwd_valid_nxt = 1'b0;
        end

        // Registered, so in_ready stays low until the first edge after reset
        // and has no combinational path from out_ready.
        in_ready_nxt = (level_nxt < LW'(DEPTH));
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            level_q     <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            overflow_q  <= 1'b0;
            fwd_valid_q <= 1'b0;
            fwd_data_q  <= '0;
        end else begin
            wr_ptr      <= wr_ptr_nxt;
            rd_ptr      <= rd_ptr_nxt;
            level_q     <= level_nxt;
            in_ready_q  <= in_ready_nxt;
            out_valid_q <= out_valid_nxt;
            out_data_q  <= out_data_nxt;
            overflow_q  <= overflow_nxt;
            fwd_valid_q <= fwd_valid_nxt;
            fwd_data_q  <= in_packed;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign level       = level_q;
    assign almost_full = (level_q >= LW'(AFULL_TH));
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_conv2d_stream_out_fifo.sv
// tb_conv2d_stream_out_fifo
// Self-checking bench: a queue-based model of the FIFO is compared against the
// DUT on every falling edge, plus literal expectations at key points.
module tb_conv2d_stream_out_fifo;
    import conv2d_pkg::*;

    localparam int NUM_CH = NUM_OUT_CHANNELS;
    localparam int PX_W   = PX_W_DEFAULT;
    localparam int DW     = VEC_W_DEFAULT;
    localparam int DEPTH  = 32;
    localparam int AFULL  = DEPTH - 4;

    logic                        clk = 1'b0;
    logic                        rst = 1'b1;
    logic [NUM_CH-1:0][PX_W-1:0] in_vec = '0;
    logic                        in_valid = 1'b0;
    logic                        in_ready;
    logic [DW-1:0]               out_data;
    logic                        out_valid;
    logic                        out_ready = 1'b0;
    logic                        flush = 1'b0;
    logic [$clog2(DEPTH):0]      level;
    logic                        almost_full;
    logic                        overflow;

    int n_tests = 0;
    int n_fail  = 0;

    conv2d_stream_out_fifo #(
        .NUM_CH   (NUM_CH),
        .PX_W     (PX_W),
        .DEPTH    (DEPTH),
        .AFULL_TH (AFULL)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_px_vec_q (in_vec),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .flush       (flush),
        .level       (level),
        .almost_full (almost_full),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 20)
                $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // Channel i lands at bits [(NUM_CH-1-i)*PX_W +: PX_W].
    function automatic px_vec_t pack(input logic [NUM_CH-1:0][PX_W-1:0] v);
        px_vec_t r = '0;
        for (int i = 0; i < NUM_CH; i++) r[(NUM_CH-1-i)*PX_W +: PX_W] = v[i];
        return r;
    endfunction

    // Behavioural model: a queue of held vectors plus the two flags.
    px_vec_t m_q[$];
    logic    m_in_ready = 1'b0;
    logic    m_ovf = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_q.delete();
            m_in_ready <= 1'b0;
            m_ovf      <= 1'b0;
        end else if (flush) begin
            m_q.delete();
            m_in_ready <= 1'b1;
            m_ovf      <= 1'b0;
        end else begin
            if (in_valid && !m_in_ready) m_ovf <= 1'b1;
            if (m_q.size() > 0 && out_ready) void'(m_q.pop_front());
            if (in_valid && m_in_ready) m_q.push_back(pack(in_vec));
            m_in_ready <= (m_q.size() < DEPTH);
        end
    end

    // Compare process, away from the rising edge.
    always @(negedge clk) begin
        check("level", DW'(level), DW'(m_q.size()));
        check("out_valid", DW'(out_valid), DW'(m_q.size() > 0));
        check("in_ready", DW'(in_ready), DW'(m_in_ready));
        check("almost_full", DW'(almost_full), DW'(m_q.size() >= AFULL));
        check("overflow", DW'(overflow), DW'(m_ovf));
        if (m_q.size() > 0) check("out_data", out_data, m_q[0]);
        if (rst) check("out_data_rst", out_data, '0);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_vec();
        for (int i = 0; i < NUM_CH; i++) in_vec[i] = PX_W'($urandom);
    endtask

    initial begin
        // Reset state
        repeat (3) tick();
        check("rst_level", DW'(level), '0);
        check("rst_out_valid", DW'(out_valid), '0);
        check("rst_in_ready", DW'(in_ready), '0);
        check("rst_almost_full", DW'(almost_full), '0);
        check("rst_overflow", DW'(overflow), '0);
        check("rst_out_data", out_data, '0);
        rst = 1'b0;
        check("in_ready_before_edge", DW'(in_ready), '0);
        tick();
        check("in_ready_after_release", DW'(in_ready), DW'(1));

        // Packing and one-cycle fall-through
        for (int i = 0; i < NUM_CH; i++) in_vec[i] = PX_W'(i);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        check("pack_out_valid", DW'(out_valid), DW'(1));
        check("pack_out_data", out_data, 128'h000102030405060708090a0b0c0d0e0f);
        check("pack_level", DW'(level), DW'(1));
        in_valid = 1'b0;
        tick();
        check("pack_drained", DW'(out_valid), '0);

        // Fill to capacity with the consumer stalled
        out_ready = 1'b0;
        for (int k = 1; k <= DEPTH; k++) begin
            rand_vec();
            in_valid = 1'b1;
            tick();
            check("fill_level", DW'(level), DW'(k));
            check("fill_almost_full", DW'(almost_full), DW'(k >= AFULL));
            check("fill_in_ready", DW'(in_ready), DW'(k < DEPTH));
        end

        // Offer while full: overflow sets, nothing is lost
        rand_vec();
        tick();
        check("ovf_set", DW'(overflow), DW'(1));
        check("ovf_level", DW'(level), DW'(DEPTH));

        // Single pops while full, producer always offering; 100 pointer wraps
        for (int w = 0; w < 100 * DEPTH; w++) begin
            out_ready = 1'b1;
            rand_vec();
            tick();
            out_ready = 1'b0;
            rand_vec();
            tick();
            check("wrap_level", DW'(level), DW'(DEPTH));
        end
        check("ovf_sticky", DW'(overflow), DW'(1));
        in_valid = 1'b0;
        flush    = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_overflow", DW'(overflow), '0);
        check("flush_level", DW'(level), '0);
        check("flush_out_valid", DW'(out_valid), '0);

        // Random traffic with occasional flushes
        for (int c = 0; c < 10000; c++) begin
            rand_vec();
            in_valid  = $urandom_range(0, 1) == 1;
            out_ready = $urandom_range(0, 1) == 1;
            flush     = $urandom_range(0, 499) == 0;
            tick();
        end
        flush = 1'b0;

        // Reset with ten vectors held
        in_valid  = 1'b0;
        out_ready = 1'b0;
        flush     = 1'b1;
        tick();
        flush = 1'b0;
        for (int k = 0; k < 10; k++) begin
            rand_vec();
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        check("pre_rst_level", DW'(level), DW'(10));
        rst = 1'b1;
        #1;
        check("rst_mid_out_valid", DW'(out_valid), '0);
        check("rst_mid_level", DW'(level), '0);
        tick();
        tick();
        rst = 1'b0;
        check("rerst_in_ready_low", DW'(in_ready), '0);
        tick();
        check("rerst_in_ready_high", DW'(in_ready), DW'(1));
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/conv2d_stream_out_fifo.md
CONV2D_STREAM_OUT_FIFO -- requirements
Module: conv2d_stream_out_fifo

Interface
REQ-001 The block SHALL take parameter NUM_CH, default 16, meaning output channels per pixel vector (1..64).
REQ-002 The block SHALL take parameter PX_W, default 8, meaning bits per quantised channel value (1..32).
REQ-003 The block SHALL take parameter DEPTH, default 32, meaning total vector capacity (power of two, 2..1024).
REQ-004 The block SHALL take parameter AFULL_TH, default DEPTH-4, meaning the level at which almost_full asserts (1..DEPTH).
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-007 The block SHALL have port in_px_vec_q, input, NUM_CH x PX_W: per-channel quantised pixel values.
REQ-008 The block SHALL have port in_valid, input, 1 bit: the producer offers in_px_vec_q.
REQ-009 The block SHALL have port in_ready, output, 1 bit: the block accepts a vector this cycle.
REQ-010 The block SHALL have port out_data, output, NUM_CH*PX_W bits: the packed vector.
REQ-011 The block SHALL have port out_valid, output, 1 bit: out_data holds a valid vector.
REQ-012 The block SHALL have port out_ready, input, 1 bit: the consumer accepts out_data.
REQ-013 The block SHALL have port flush, input, 1 bit: synchronous discard of all contents.
REQ-014 The block SHALL have port level, output, $clog2(DEPTH)+1 bits: vectors held, including the output register.
REQ-015 The block SHALL have port almost_full, output, 1 bit: asserted when level >= AFULL_TH.
REQ-016 The block SHALL have port overflow, output, 1 bit: sticky flag for in_valid while in_ready is low.

Function
REQ-017 Packing SHALL place channel i at out_data bits [(NUM_CH-1-i)*PX_W +: PX_W], so channel 0 occupies the MSBs.
REQ-018 A push SHALL occur exactly when in_valid && in_ready, and a pop exactly when out_valid && out_ready.
REQ-019 in_ready SHALL equal (level < DEPTH), driven only from registered state with no combinational path from out_ready.
REQ-020 Output SHALL be first-word-fall-through: a push into an empty block makes out_valid high on the next edge, giving 1-cycle latency.
REQ-021 out_valid and out_data SHALL be registered, and while out_valid && !out_ready they SHALL hold stable.
REQ-022 After a pop, the next stored vector SHALL appear on out_data on the following edge with no bubble while level > 1.
REQ-023 A simultaneous push and pop SHALL leave level unchanged and preserve FIFO order, both when empty (+1 -1) and when full.
REQ-024 Read and write pointers SHALL wrap modulo DEPTH silently.
REQ-025 level SHALL be exact, never exceed DEPTH, and never underflow.
REQ-026 overflow SHALL set on any cycle with in_valid && !in_ready, hold until flush or rst, and drop nothing already stored.
REQ-027 flush SHALL, on the next edge, zero level, deassert out_valid, clear overflow and reset pointers, with flush taking priority over any concurrent push or pop.
REQ-028 The memory SHALL NOT require reset, and out_data SHALL be don't-care while out_valid is low.

Reset
REQ-029 While rst is high, level=0, out_valid=0, in_ready=0, almost_full=0, overflow=0, out_data=0, and pointers SHALL be 0.
REQ-030 in_ready SHALL assert on the first edge after rst deasserts.
REQ-031 Reset asserted mid-transfer SHALL discard all contents immediately, with no partial output.

Structure
REQ-032 Shared package conv2d_pkg SHALL hold NUM_OUT_CHANNELS, PX_W_DEFAULT, and a packed vector typedef px_vec_t.
REQ-033 Storage SHALL be a sub-module conv2d_fifo_ram (simple dual-port, sync write, sync read, no reset).
REQ-034 The top SHALL contain the pointers, level counter, FWFT output stage, and flags.

Verification
REQ-035 The bench SHALL push channels 0..15 = 8'h00..8'h0F with out_ready=1; out_data SHALL equal 128'h000102..0F one cycle later.
REQ-036 The bench SHALL push 32 vectors with out_ready=0; level SHALL reach 32, in_ready SHALL fall, and almost_full SHALL be high from level 28.
REQ-037 With the block full, the bench SHALL hold in_valid=1 and pulse out_ready once; exactly one vector SHALL be popped, one pushed, level SHALL stay 32, and order SHALL be preserved over 100 wraps.
REQ-038 The bench SHALL drive in_valid while full; overflow SHALL set and stay set until flush, with contents intact.
REQ-039 The bench SHALL apply random in_valid/out_ready at 50% for 10k cycles against a scoreboard; there SHALL be no loss, duplication or reorder, and out_data SHALL be stable under stall.
REQ-040 The bench SHALL assert rst with 10 vectors held; out_valid and level SHALL be 0 in the same cycle, and in_ready SHALL be 1 one edge after release.
